y_mat_addr_packer: RTL and testbench
====================================

Name: y_mat_addr_packer

Overview:
- Write-side counterpart of the Y-matrix address lookup.
- Accepts a stream of per-row Y-matrix addresses, packs 16 of them into one 256-bit SRAM word in the lane order the read-side extractor expects, and issues the word as an SRAM write with a ready/ack handshake.
- Sits between the Y-matrix index generator and the SRAM write port.
- Supports partial-word flush at the end of a matrix.

Parameters:
- SRAM_AW, 11, SRAM word-address width.
- LANES, 16, entries per 256-bit word (fixed; lane width 16 bits).
- ADDR_W, 11, input address width; only bits [9:0] are stored.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pk_start  in  1  pulse; loads pk_base_addr, clears lane and word counters; ignored unless IDLE
- pk_base_addr  in  SRAM_AW  first SRAM word address
- pk_in_valid  in  1  input entry valid
- pk_in_addr  in  ADDR_W  Y-matrix row address
- pk_in_ready  out  1  entry accepted when valid&ready
- pk_flush  in  1  pulse; close the current partial word
- pk_wr_en  out  1  write request, held until acked
- pk_wr_addr  out  SRAM_AW  SRAM word address
- pk_wr_data  out  256  packed word
- pk_wr_ack  in  1  SRAM accepted the write this cycle
- pk_busy  out  1  not IDLE
- pk_done  out  1  one-cycle pulse when a flush has fully retired
- pk_words  out  SRAM_AW  words written since pk_start

Behaviour:
- Reset: all outputs 0, state IDLE, buffers cleared. Reset mid-write abandons the request; pk_wr_en drops the next cycle.
- Lane mapping: the k-th accepted entry of a word (k = 0..15) goes to lane L = 15-k, i.e. row index r = (k+1) mod 16 and L = (16-r) mod 16. Lane L occupies bits [16L+15:16L]:
  - data = pk_in_addr[9:0] in [16L+9:16L]
  - bits [16L+15:16L+10] = 0
  - pk_in_addr[10] is discarded
  - Result: first entry lands in [249:240], 16th entry in [9:0].
- States:
  - IDLE:
    - pk_in_ready = 0.
    - pk_start → FILL, wr address = base, k = 0, pk_words = 0, fill buffer zeroed.
  - FILL:
    - pk_in_ready = 1.
    - Each accepted entry writes lane 15-k and increments k.
    - The 16th accept, or pk_flush with k > 0, moves the buffer to the output register → WRITE.
    - pk_flush with k = 0 → pk_done pulse next cycle → IDLE.
  - WRITE:
    - pk_wr_en = 1; pk_wr_addr and pk_wr_data are stable until pk_wr_ack.
    - On ack: wr address +1 (wraps mod 2^SRAM_AW), pk_words +1.
    - Then → FILL with k = 0 and the buffer cleared, or, if a flush is pending, pk_done pulse → IDLE.
    - pk_in_ready = 0 in WRITE.
- Unfilled lanes of a flushed word read as zero.
- Simultaneous valid&ready and pk_flush: the entry is accepted first, then the flush applies. If that entry completes the word, exactly one write is issued.
- pk_flush during WRITE is latched as pending.
- pk_start outside IDLE is ignored.
- Latency: the 16th accept is followed by pk_wr_en on the next cycle. An ack on the first cycle of pk_wr_en is legal (minimum one-cycle write).

Optional Feature:
- Macro PK_DOUBLE_BUF_EN.
- Defined:
  - A separate output register lets FILL continue during WRITE; pk_in_ready stays high while the output register is occupied and the fill buffer is not full.
  - If a second word completes before ack, pk_in_ready drops until the ack.
  - Writes retire in order. pk_done fires after the last outstanding write acks.
- Undefined: single buffer, pk_in_ready = 0 throughout WRITE, as above.

Decomposition:
- Package y_mat_pkg holds:
  - LANES, LANE_W = 16, ADDR_DATA_W = 10
  - state enum {IDLE, FILL, WRITE}
  - function lane_lsb(k) = 16*(15-k), shared with the read-side extractor so the mapping has one definition.
- One natural sub-module: y_mat_lane_buf (256-bit accumulate register with lane-indexed write and clear).

Test Plan:
- Start base 0x010; feed addresses 1..16 with no backpressure, ack immediately → one write at 0x010 with [249:240]=1, [233:224]=2, …, [9:0]=16 (0x010); upper 6 bits of every lane 0; pk_words = 1.
- Feed 0x7FF (bit 10 set) as the first entry → lane 15 = 0x03FF; bit 10 dropped.
- Feed 3 entries (0x00A, 0x00B, 0x00C), then flush → one write with [249:240]=0x00A, [233:224]=0x00B, [217:208]=0x00C, other bits 0; pk_done pulses one cycle after the ack; back in IDLE.
- Flush with k = 0 → no pk_wr_en; pk_done pulses; pk_words unchanged.
- Base 0x7FF, 32 entries, ack delayed 5 cycles → writes at 0x7FF then 0x000; pk_wr_data is stable while waiting; pk_in_ready = 0 during WRITE (without PK_DOUBLE_BUF_EN).
- Assert reset during WRITE → pk_wr_en = 0 and all outputs 0 on the next cycle; a later pk_start begins cleanly.

Source files
------------

// File: rtl/y_mat_pkg.sv
// rtl/y_mat_pkg.sv - shared Y-matrix lane geometry, packer states and the lane-to-bit mapping
package y_mat_pkg;

    localparam int LANES       = 16;
    localparam int LANE_W      = 16;
    localparam int ADDR_DATA_W = 10;
    localparam int LANE_IDX_W  = 4;
    localparam int WORD_W      = LANES * LANE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } packState_t;

    // Entry k of a word lives in lane 15-k; the read-side extractor uses the same helper.
    function automatic logic [7:0] lane_lsb(input logic [LANE_IDX_W-1:0] k);
        return 8'(LANE_W * (LANES - 1 - int'(k)));
    endfunction

endpackage

// File: rtl/y_mat_lane_buf.sv
// rtl/y_mat_lane_buf.sv - 256-bit fill buffer with lane-indexed write and whole-word clear
module y_mat_lane_buf
    import y_mat_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   wrEn,
    input  logic [LANE_IDX_W-1:0]  wrIdx,
    input  logic [ADDR_DATA_W-1:0] wrData,
    output logic [WORD_W-1:0]      wordNext
);

    logic [WORD_W-1:0] word;

    // Merged view: the stored word with this cycle's entry already placed, so a word can
    // be handed off on the same edge that accepts its last entry.
    always_comb begin
        wordNext = word;
        if (wrEn) begin
            wordNext[lane_lsb(wrIdx) +: LANE_W] = LANE_W'(wrData);
        end
    end

    // Clear wins over the merge; a cleared buffer starts the next word with all lanes zero.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            word <= '0;
        end else begin
            word <= wordNext;
        end
    end

endmodule

// File: rtl/y_mat_addr_packer.sv
// rtl/y_mat_addr_packer.sv - packs Y-matrix row addresses into SRAM words; PK_DOUBLE_BUF_EN adds fill-during-write
module y_mat_addr_packer
    import y_mat_pkg::*;
#(
    parameter int SRAM_AW = 11,
    parameter int ADDR_W  = 11
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pk_start,
    input  logic [SRAM_AW-1:0] pk_base_addr,
    input  logic               pk_in_valid,
    input  logic [ADDR_W-1:0]  pk_in_addr,
    output logic               pk_in_ready,
    input  logic               pk_flush,
    output logic               pk_wr_en,
    output logic [SRAM_AW-1:0] pk_wr_addr,
    output logic [WORD_W-1:0]  pk_wr_data,
    input  logic               pk_wr_ack,
    output logic               pk_busy,
    output logic               pk_done,
    output logic [SRAM_AW-1:0] pk_words
);

    packState_t              state;
    logic [LANE_IDX_W-1:0]   fillIdx;
    logic [SRAM_AW-1:0]      wrAddr;
    logic [SRAM_AW-1:0]      wordCount;
    logic [WORD_W-1:0]       outWord;
    logic                    outValid;
    logic                    pendingMove;
    logic                    flushPending;
    logic                    doneReg;

    logic [WORD_W-1:0]       bufNext;
    logic                    startNow;
    logic                    accept;
    logic                    lastEntry;
    logic                    closeNow;
    logic                    ackTaken;
    logic                    outFree;
    logic                    moveNow;
    logic                    outValidNext;
    logic                    pendingMoveNext;
    logic                    flushSeen;
    logic                    doneNow;
    logic                    fillHalt;
    logic                    bufClear;
    logic                    unusedAddrHi;

    // Address bits above the stored field are dropped by design.
    assign unusedAddrHi = ^pk_in_addr[ADDR_W-1:ADDR_DATA_W];

    assign startNow    = (state == IDLE) && pk_start;
    assign pk_in_ready = (state == FILL);
    assign accept      = pk_in_valid && pk_in_ready;
    assign lastEntry   = accept && (fillIdx == LANE_IDX_W'(LANES - 1));

    // A word closes on its 16th entry, or on flush if it holds at least one entry
    // (an entry accepted together with the flush counts).
    assign closeNow = lastEntry
                   || (pk_flush && (state == FILL) && (accept || (fillIdx != '0)));

    // The output register frees up on the ack edge, so a waiting word can follow at once.
    assign ackTaken        = outValid && pk_wr_ack;
    assign outFree         = !outValid || pk_wr_ack;
    assign moveNow         = (closeNow || pendingMove) && outFree;
    assign outValidNext    = moveNow || (outValid && !pk_wr_ack);
    assign pendingMoveNext = (closeNow || pendingMove) && !moveNow;

    // The matrix is finished once a flush has been seen and nothing remains to write.
    assign flushSeen = (state != IDLE) && (flushPending || pk_flush);
    assign doneNow   = flushSeen && !outValidNext && !pendingMoveNext;

`ifdef PK_DOUBLE_BUF_EN
    assign fillHalt = pendingMoveNext || flushSeen;
`else
    assign fillHalt = outValidNext || flushSeen;
`endif

    assign bufClear = startNow || moveNow;

    y_mat_lane_buf uLaneBuf (
        .clock    (clock),
        .reset    (reset),
        .clear    (bufClear),
        .wrEn     (accept),
        .wrIdx    (fillIdx),
        .wrData   (pk_in_addr[ADDR_DATA_W-1:0]),
        .wordNext (bufNext)
    );

    // Sequencing: start, fill, hand-off to the output register, retire on ack, finish on flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            fillIdx      <= '0;
            outValid     <= 1'b0;
            pendingMove  <= 1'b0;
            flushPending <= 1'b0;
            doneReg      <= 1'b0;
        end else begin
            doneReg <= doneNow;
            if (startNow) begin
                state        <= FILL;
                fillIdx      <= '0;
                outValid     <= 1'b0;
                pendingMove  <= 1'b0;
                flushPending <= 1'b0;
            end else if (state != IDLE) begin
                if (closeNow) begin
                    fillIdx <= '0;
                end else if (accept) begin
                    fillIdx <= fillIdx + LANE_IDX_W'(1);
                end
                outValid     <= outValidNext;
                pendingMove  <= pendingMoveNext;
                flushPending <= flushSeen && !doneNow;
                if (doneNow) begin
                    state <= IDLE;
                end else if (fillHalt) begin
                    state <= WRITE;
                end else begin
                    state <= FILL;
                end
            end
        end
    end

    // Write datapath: word, address and count advance only on a taken ack, so writes retire in order.
    always_ff @(posedge clock) begin
        if (reset) begin
            outWord   <= '0;
            wrAddr    <= '0;
            wordCount <= '0;
        end else if (startNow) begin
            wrAddr    <= pk_base_addr;
            wordCount <= '0;
        end else if (state != IDLE) begin
            if (moveNow) begin
                outWord <= bufNext;
            end
            if (ackTaken) begin
                wrAddr    <= wrAddr + SRAM_AW'(1);
                wordCount <= wordCount + SRAM_AW'(1);
            end
        end
    end

    assign pk_wr_en   = outValid;
    assign pk_wr_addr = wrAddr;
    assign pk_wr_data = outWord;
    assign pk_busy    = (state != IDLE);
    assign pk_done    = doneReg;
    assign pk_words   = wordCount;

endmodule

// File: tb/tb_y_mat_addr_packer.sv
// tb/tb_y_mat_addr_packer.sv - directed self-checking bench for y_mat_addr_packer
module tb_y_mat_addr_packer;

    logic         clock = 1'b0;
    logic         reset;
    logic         pk_start;
    logic [10:0]  pk_base_addr;
    logic         pk_in_valid;
    logic [10:0]  pk_in_addr;
    logic         pk_in_ready;
    logic         pk_flush;
    logic         pk_wr_en;
    logic [10:0]  pk_wr_addr;
    logic [255:0] pk_wr_data;
    logic         pk_wr_ack;
    logic         pk_busy;
    logic         pk_done;
    logic [10:0]  pk_words;

    int errCount   = 0;
    int checkCount = 0;

    always #5 clock = ~clock;

    y_mat_addr_packer #(.SRAM_AW(11), .ADDR_W(11)) dut (
        .clock        (clock),
        .reset        (reset),
        .pk_start     (pk_start),
        .pk_base_addr (pk_base_addr),
        .pk_in_valid  (pk_in_valid),
        .pk_in_addr   (pk_in_addr),
        .pk_in_ready  (pk_in_ready),
        .pk_flush     (pk_flush),
        .pk_wr_en     (pk_wr_en),
        .pk_wr_addr   (pk_wr_addr),
        .pk_wr_data   (pk_wr_data),
        .pk_wr_ack    (pk_wr_ack),
        .pk_busy      (pk_busy),
        .pk_done      (pk_done),
        .pk_words     (pk_words)
    );

    task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic pulseStart(input logic [10:0] base);
        pk_start     = 1'b1;
        pk_base_addr = base;
        tick();
        pk_start = 1'b0;
    endtask

    task automatic pulseFlush();
        pk_flush = 1'b1;
        tick();
        pk_flush = 1'b0;
    endtask

    task automatic pushEntry(input logic [10:0] val);
        int waitCnt = 0;
        pk_in_valid = 1'b1;
        pk_in_addr  = val;
        while (!pk_in_ready && waitCnt < 50) begin
            tick();
            waitCnt++;
        end
        checkVal("push_ready", pk_in_ready, 1);
        tick();
        pk_in_valid = 1'b0;
    endtask

    task automatic ackWrite(input int delay, input logic [255:0] expData,
                            input logic [10:0] expAddr, input string tag);
        int waitCnt = 0;
        while (!pk_wr_en && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        checkVal({tag, "_wr_en"}, pk_wr_en, 1);
        for (int c = 0; c <= delay; c++) begin
            checkVal({tag, "_data"}, pk_wr_data, expData);
            checkVal({tag, "_addr"}, pk_wr_addr, expAddr);
`ifndef PK_DOUBLE_BUF_EN
            checkVal({tag, "_ready_low"}, pk_in_ready, 0);
`endif
            if (c == delay) begin
                pk_wr_ack = 1'b1;
            end
            tick();
        end
        pk_wr_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] expA;
        logic [255:0] expB;
        logic [255:0] expC;
        logic [10:0]  val;

        reset        = 1'b1;
        pk_start     = 1'b0;
        pk_base_addr = '0;
        pk_in_valid  = 1'b0;
        pk_in_addr   = '0;
        pk_flush     = 1'b0;
        pk_wr_ack    = 1'b0;
        repeat (3) tick();

        checkVal("rst_wr_en", pk_wr_en, 0);
        checkVal("rst_busy", pk_busy, 0);
        checkVal("rst_done", pk_done, 0);
        checkVal("rst_words", pk_words, 0);
        checkVal("rst_addr", pk_wr_addr, 0);
        checkVal("rst_data", pk_wr_data, 0);
        checkVal("rst_ready", pk_in_ready, 0);
        reset = 1'b0;
        tick();

        // Full word, ack on the first write cycle.
        pulseStart(11'h010);
        checkVal("t1_busy", pk_busy, 1);
        checkVal("t1_ready", pk_in_ready, 1);
        checkVal("t1_addr", pk_wr_addr, 11'h010);
        for (int i = 1; i <= 16; i++) begin
            pushEntry(11'(i));
        end
        checkVal("t1_latency", pk_wr_en, 1);
        ackWrite(0, 256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A_000B_000C_000D_000E_000F_0010,
                 11'h010, "t1");
        checkVal("t1_words", pk_words, 1);
        checkVal("t1_wr_en_off", pk_wr_en, 0);
        checkVal("t1_refill", pk_in_ready, 1);
        checkVal("t1_no_done", pk_done, 0);

        // Bit 10 dropped; single entry flushed.
        pushEntry(11'h7FF);
        pulseFlush();
        ackWrite(0, {16'h03FF, 240'h0}, 11'h011, "t2");
        checkVal("t2_done", pk_done, 1);
        checkVal("t2_idle", pk_busy, 0);
        checkVal("t2_words", pk_words, 2);
        tick();
        checkVal("t2_done_pulse", pk_done, 0);

        // Partial word of three entries, ack one cycle late.
        pulseStart(11'h020);
        pushEntry(11'h00A);
        pushEntry(11'h00B);
        pushEntry(11'h00C);
        pulseFlush();
        ackWrite(1, {16'h000A, 16'h000B, 16'h000C, 208'h0}, 11'h020, "t3");
        checkVal("t3_done", pk_done, 1);
        checkVal("t3_idle", pk_busy, 0);
        checkVal("t3_words", pk_words, 1);
        checkVal("t3_wr_en_off", pk_wr_en, 0);
        tick();
        checkVal("t3_done_pulse", pk_done, 0);

        // Flush of an empty word.
        pulseStart(11'h030);
        pulseFlush();
        checkVal("t4_done", pk_done, 1);
        checkVal("t4_no_write", pk_wr_en, 0);
        checkVal("t4_idle", pk_busy, 0);
        checkVal("t4_words", pk_words, 0);
        tick();
        checkVal("t4_done_pulse", pk_done, 0);

        // Two words from base 0x7FF with slow acks; address wraps; mid-fill start ignored.
        expA = '0;
        expB = '0;
        pulseStart(11'h7FF);
        for (int k = 0; k < 16; k++) begin
            val = 11'h400 + 11'(k * 37);
            expA[16*(15-k) +: 16] = {6'h0, val[9:0]};
            pushEntry(val);
        end
        checkVal("t5a_latency", pk_wr_en, 1);
        ackWrite(5, expA, 11'h7FF, "t5a");
        checkVal("t5a_words", pk_words, 1);
        checkVal("t5a_wrap", pk_wr_addr, 11'h000);
        for (int k = 0; k < 16; k++) begin
            val = 11'h7C0 + 11'(k);
            expB[16*(15-k) +: 16] = {6'h0, val[9:0]};
            pushEntry(val);
            if (k == 7) begin
                pulseStart(11'h123);
                checkVal("t5_start_ignored", pk_wr_addr, 11'h000);
                checkVal("t5_still_busy", pk_busy, 1);
            end
        end
        ackWrite(5, expB, 11'h000, "t5b");
        checkVal("t5b_words", pk_words, 2);
        pulseFlush();
        checkVal("t5_done", pk_done, 1);
        checkVal("t5_final_words", pk_words, 2);

        // Reset while a write is outstanding, then a clean restart.
        pulseStart(11'h055);
        for (int i = 0; i < 16; i++) begin
            pushEntry(11'(i));
        end
        checkVal("t6_pending", pk_wr_en, 1);
        reset = 1'b1;
        tick();
        checkVal("t6_rst_wr_en", pk_wr_en, 0);
        checkVal("t6_rst_busy", pk_busy, 0);
        checkVal("t6_rst_data", pk_wr_data, 0);
        checkVal("t6_rst_addr", pk_wr_addr, 0);
        checkVal("t6_rst_words", pk_words, 0);
        checkVal("t6_rst_ready", pk_in_ready, 0);
        checkVal("t6_rst_done", pk_done, 0);
        reset = 1'b0;
        tick();

        // Last entry and flush in the same cycle give exactly one write.
        expC = '0;
        pulseStart(11'h066);
        for (int k = 0; k < 15; k++) begin
            val = 11'h300 + 11'(k);
            expC[16*(15-k) +: 16] = {6'h0, val[9:0]};
            pushEntry(val);
        end
        expC[15:0] = 16'h030F;
        pk_in_valid = 1'b1;
        pk_in_addr  = 11'h30F;
        pk_flush    = 1'b1;
        tick();
        pk_in_valid = 1'b0;
        pk_flush    = 1'b0;
        ackWrite(0, expC, 11'h066, "t6");
        checkVal("t6_done", pk_done, 1);
        checkVal("t6_wr_en_off", pk_wr_en, 0);
        checkVal("t6_words", pk_words, 1);
        tick();
        checkVal("t6_single_write", pk_wr_en, 0);
        checkVal("t6_done_pulse", pk_done, 0);
        checkVal("t6_idle", pk_busy, 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
